// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, defaults and
// the index-width helper used for port and register sizing.
package arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Never returns less than 1 so that a width derived from it stays legal.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: starting at start_i and wrapping, the first
// requester that is asserted and not masked by excl_i wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    start_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] cand;
  assign cand = req_i & ~excl_i;

  int            pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(start_i) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = IW'(pos);
      if (!found_o && cand[pos_idx]) begin
        found_o           = 1'b1;
        idx_o             = pos_idx;
        onehot_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with a bounded hold time under contention.
// All outputs are registered; the current FSM state is exposed on dbg_state_o.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          gnt,
  output logic                      gnt_valid,
  output logic [clog2(N_REQ)-1:0]   gnt_id,
  output arb_state_e                dbg_state_o
);

  localparam int              IW       = clog2(N_REQ);
  localparam int              HW       = clog2(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             holder_req;
  logic             others_req;
  logic             keep;

  // Excluding the current holder only matters when its hold budget is spent;
  // in IDLE gnt_q is zero so nothing is excluded.
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req),
    .start_i  (ptr_q),
    .excl_i   (gnt_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign holder_req = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign keep       = (state_q == GRANT) && holder_req &&
                      (!others_req || (hold_cnt_q != HOLD_MAX));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (keep) begin
      if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
    end else if (pick_found) begin
      state_d    = GRANT;
      gnt_d      = pick_onehot;
      valid_d    = 1'b1;
      id_d       = pick_idx;
      hold_cnt_d = '0;
      ptr_d      = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    end else begin
      state_d    = IDLE;
      gnt_d      = '0;
      valid_d    = 1'b0;
      id_d       = '0;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = valid_q;
  assign gnt_id      = id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: six instances with different N_REQ / MAX_HOLD share
// one clock and reset and are compared every cycle against a reference model.
module tb_rr_arbiter_n;
  import arb_pkg::*;

  localparam int NI = 6;

  function automatic int cfg_n(input int g);
    case (g)
      0, 1, 2: return 4;
      3:       return 2;
      4:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_mh(input int g);
    case (g)
      0:       return 8;
      1:       return 2;
      2:       return 1;
      3:       return 3;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  logic       clk;
  logic       rst;
  logic [7:0] req_v [NI];
  logic [7:0] gnt_v [NI];
  logic [2:0] id_v  [NI];
  logic       val_v [NI];
  logic       st_v  [NI];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N  = cfg_n(g);
    localparam int MH = cfg_mh(g);
    localparam int IW = arb_pkg::clog2(N);
    logic [N-1:0]  gnt_w;
    logic [IW-1:0] id_w;
    logic          v_w;
    arb_state_e    st_w;

    rr_arbiter_n #(.N_REQ(N), .MAX_HOLD(MH)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req_v[g][N-1:0]),
      .gnt         (gnt_w),
      .gnt_valid   (v_w),
      .gnt_id      (id_w),
      .dbg_state_o (st_w)
    );

    assign gnt_v[g] = 8'(gnt_w);
    assign id_v[g]  = 3'(id_w);
    assign val_v[g] = v_w;
    assign st_v[g]  = (st_w == GRANT);
  end

  // ---------------- reference model ----------------
  // holder is -1 when nothing is granted; held counts edges since the grant began.
  int m_hold [NI];
  int m_ptr  [NI];
  int m_held [NI];
  int m_wait [NI][8];

  int n_vec;
  int n_err;
  logic [2:0] exp_q[$];

  function automatic bit bit_of(input logic [7:0] v, input int i);
    return v[i[2:0]];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_hold[k] = -1;
      m_ptr[k]  = 0;
      m_held[k] = 0;
      for (int i = 0; i < 8; i++) m_wait[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int  n, mh, h, w, c;
    bit  others;
    n = cfg_n(k);
    mh = cfg_mh(k);
    h = m_hold[k];
    w = -1;
    others = 1'b0;
    for (int j = 0; j < n; j++)
      if (bit_of(req_v[k], j) && j != h) others = 1'b1;
    if (h >= 0 && bit_of(req_v[k], h) && (!others || m_held[k] < mh - 1)) begin
      if (m_held[k] < mh - 1) m_held[k] = m_held[k] + 1;
    end else begin
      for (int j = 0; j < n; j++) begin
        c = (m_ptr[k] + j) % n;
        if (w < 0 && bit_of(req_v[k], c) && c != h) w = c;
      end
      if (w >= 0) begin
        m_hold[k] = w;
        m_held[k] = 0;
        m_ptr[k]  = (w + 1) % n;
      end else begin
        m_hold[k] = -1;
        m_held[k] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int k, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[inst %0d] got %0d exp %0d", tag, k, got, exp);
    end
  endtask

  task automatic check(input int k);
    int n, mh, eg, ei, ev, worst;
    n  = cfg_n(k);
    mh = cfg_mh(k);
    eg = (m_hold[k] >= 0) ? (1 << m_hold[k]) : 0;
    ei = (m_hold[k] >= 0) ? m_hold[k] : 0;
    ev = (m_hold[k] >= 0) ? 1 : 0;
    chk("gnt",    k, int'(gnt_v[k]), eg);
    chk("valid",  k, int'(val_v[k]), ev);
    chk("gnt_id", k, int'(id_v[k]),  ei);
    chk("state",  k, int'(st_v[k]),  ev);
    chk("onehot", k, int'($countones(gnt_v[k]) <= 1), 1);
    chk("id_bit", k, int'(gnt_v[k] == 8'd0 || bit_of(gnt_v[k], int'(id_v[k]))), 1);
    worst = 0;
    for (int i = 0; i < n; i++) begin
      if (bit_of(req_v[k], i) && !bit_of(gnt_v[k], i)) m_wait[k][i] = m_wait[k][i] + 1;
      else m_wait[k][i] = 0;
      if (m_wait[k][i] > worst) worst = m_wait[k][i];
    end
    chk("starve", k, int'(worst <= (n - 1) * mh + 1), 1);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (rst) model_reset();
      else model_step(k);
    end
    for (int k = 0; k < NI; k++) check(k);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) req_v[k] = 8'd0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;

    // Lone requester keeps its grant far beyond MAX_HOLD.
    req_v[0] = 8'h04;
    repeat (20) begin
      step();
      chk("single_hold", 0, int'(gnt_v[0]), 4);
    end
    req_v[0] = 8'h00;
    step();
    chk("idle_valid", 0, int'(val_v[0]), 0);

    // Full contention: MAX_HOLD=2 pairs, MAX_HOLD=1 rotates every cycle.
    for (int i = 0; i < 9; i++) exp_q.push_back(3'((i / 2) % 4));
    req_v[1] = 8'h0F;
    req_v[2] = 8'h0F;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rot_mh2", 1, int'(id_v[1]), int'(exp_q.pop_front()));
      chk("rot_mh1", 2, int'(id_v[2]), i % 4);
    end
    req_v[1] = 8'h00;
    req_v[2] = 8'h00;
    step();

    // Idle return keeps ptr, early release hands over without a gap.
    req_v[0] = 8'h02; step(); chk("grant1", 0, int'(gnt_v[0]), 2);
    req_v[0] = 8'h00; step(); chk("idle_ret", 0, int'(val_v[0]), 0);
    req_v[0] = 8'h0B; step(); chk("ptr_kept", 0, int'(gnt_v[0]), 8);
    req_v[0] = 8'h0A; step(); chk("keep3", 0, int'(gnt_v[0]), 8);
    req_v[0] = 8'h02; step(); chk("release3", 0, int'(gnt_v[0]), 2);
    chk("no_gap_a", 0, int'(val_v[0]), 1);
    req_v[0] = 8'h0A; step(); chk("keep1", 0, int'(gnt_v[0]), 2);
    req_v[0] = 8'h08; step(); chk("release1", 0, int'(gnt_v[0]), 8);
    chk("no_gap_b", 0, int'(val_v[0]), 1);

    // Asynchronous reset in the middle of a grant.
    req_v[0] = 8'h0F;
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt",   0, int'(gnt_v[0]), 0);
    chk("rst_valid", 0, int'(val_v[0]), 0);
    chk("rst_id",    0, int'(id_v[0]),  0);
    for (int k = 0; k < NI; k++) check(k);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 0, int'(gnt_v[0]), 1);
    chk("post_rst_id",  0, int'(id_v[0]),  0);

    // Random requests, held for a few cycles each so hold limits are reached.
    repeat (150) begin
      for (int k = 0; k < NI; k++) begin
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
        req_v[k] = r & 8'((1 << cfg_n(k)) - 1);
      end
      repeat ($urandom_range(1, 8)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
